// File: rtl/trace_stream_packetiser_if.sv
// Valid/ready stream carrying packetised trace records toward the trace sink.
interface trace_stream_packetiser_if #(
  parameter int TDATA_WIDTH = 32
) ();
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/trace_stream_packetiser.sv
// Buffers completed trace records and emits each one as a header beat
// (sequence number + drop count) followed by the record split into stream words.
module trace_stream_packetiser #(
  parameter int RECORD_WIDTH = 160,
  parameter int TDATA_WIDTH  = 32,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_i,
  input  logic                          trace_valid_i,
  input  logic [RECORD_WIDTH-1:0]       trace_data_i,
  trace_stream_packetiser_if.master     m,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  input  logic                          clear_overflow_i
);
  localparam int WORDS = (RECORD_WIDTH + TDATA_WIDTH - 1) / TDATA_WIDTH;
  localparam int PADW  = WORDS * TDATA_WIDTH;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int BW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t                  state_reg;
  logic [BW-1:0]           beat_reg;
  logic [AW-1:0]           wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]           count_reg;
  logic [15:0]             seq_reg, drop_reg, snap_reg;
  logic                    overflow_reg, tvalid_reg, tlast_reg;
  logic [TDATA_WIDTH-1:0]  tdata_reg;

  logic [RECORD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PADW-1:0]         head_padded;
  logic [TDATA_WIDTH-1:0]  head_words [WORDS];

  logic push_req, full, push, drop, hs, hdr_hs, pop;
  logic [15:0] drop_base, drop_next;

  function automatic logic [TDATA_WIDTH-1:0] header_word(input logic [15:0] seq,
                                                         input logic [15:0] drops);
    logic [TDATA_WIDTH-1:0] w;
    w        = '0;
    w[31:16] = seq;
    w[15:0]  = drops;
    return w;
  endfunction

  // The head record stays in place until its last beat is accepted.
  assign head_padded = PADW'(mem[rd_ptr_reg]);

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      assign head_words[gi] = head_padded[gi*TDATA_WIDTH +: TDATA_WIDTH];
    end
  endgenerate

  always_comb begin
    push_req = trace_valid_i & enable_i;
    full     = (count_reg == LW'(FIFO_DEPTH));
    push     = push_req & ~full;
    drop     = push_req & full;
    hs       = tvalid_reg & m.tready;
    hdr_hs   = hs & (state_reg == HEADER);
    pop      = hs & (state_reg == PAYLOAD) & tlast_reg;
    // Only the drops already reported in the header are retired; later ones survive.
    drop_base = hdr_hs ? (drop_reg - snap_reg) : drop_reg;
    drop_next = (drop && (drop_base != 16'hFFFF)) ? drop_base + 16'd1 : drop_base;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= trace_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      drop_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + LW'(push) - LW'(pop);
      drop_reg  <= drop_next;
      if (drop)                  overflow_reg <= 1'b1;
      else if (clear_overflow_i) overflow_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      beat_reg   <= '0;
      seq_reg    <= '0;
      snap_reg   <= '0;
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
      tdata_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (count_reg != '0) begin
            state_reg  <= HEADER;
            tvalid_reg <= 1'b1;
            tlast_reg  <= 1'b0;
            tdata_reg  <= header_word(seq_reg, drop_reg);
            snap_reg   <= drop_reg;
          end
        end
        HEADER: begin
          if (hs) begin
            state_reg <= PAYLOAD;
            beat_reg  <= '0;
            tdata_reg <= head_words[0];
            tlast_reg <= (WORDS == 1);
          end
        end
        PAYLOAD: begin
          if (hs) begin
            if (tlast_reg) begin
              seq_reg <= seq_reg + 16'd1;
              // Records behind the head start their header with no idle bubble.
              if (count_reg > LW'(1)) begin
                state_reg <= HEADER;
                tlast_reg <= 1'b0;
                tdata_reg <= header_word(seq_reg + 16'd1, drop_reg);
                snap_reg  <= drop_reg;
              end else begin
                state_reg  <= IDLE;
                tvalid_reg <= 1'b0;
                tlast_reg  <= 1'b0;
                tdata_reg  <= '0;
              end
            end else begin
              beat_reg  <= beat_reg + BW'(1);
              tdata_reg <= head_words[beat_reg + BW'(1)];
              tlast_reg <= ((beat_reg + BW'(1)) == BW'(WORDS - 1));
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m.tvalid     = tvalid_reg;
  assign m.tdata      = tdata_reg;
  assign m.tlast      = tlast_reg;
  assign fifo_level_o = count_reg;
  assign overflow_o   = overflow_reg;
endmodule
